// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin lane arbiter.
// Contents: FSM state enum, default parameter values, derived widths.
package mux_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned ARB_NUM_REQ     = 4;
  localparam int unsigned ARB_DATA_WIDTH  = 8;
  localparam int unsigned ARB_MAX_BURST   = 15;
  localparam int unsigned ARB_WDOG_CYCLES = 16;

  localparam int unsigned ARB_SRC_W   = $clog2(ARB_NUM_REQ);
  localparam int unsigned ARB_CNT_W   = $clog2(ARB_MAX_BURST + 1);
  localparam int unsigned ARB_STALL_W = $clog2(ARB_WDOG_CYCLES + 1);

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for mux_rr_arbiter.
// master: requesters + downstream sink (drives in_*, out_ready).
// slave : the arbiter (drives in_ready, out_*, grant, out_src, err).
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH
) ();

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [DATA_WIDTH-1:0] in_data [NUM_REQ];
  logic [NUM_REQ-1:0]    in_valid;
  logic [NUM_REQ-1:0]    in_last;
  logic [NUM_REQ-1:0]    in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;
  logic [NUM_REQ-1:0]    grant;
  logic [SRC_W-1:0]      out_src;
  logic                  err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant, out_src, err
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, grant, out_src, err
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req scanning upward from
// ptr+1 and wrapping, so the requester at ptr has the lowest priority.
// Ports: req (requests), ptr (last served) -> onehot, idx, any.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int unsigned cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                       = 1'b1;
        onehot[cand[IDX_W-1:0]]   = 1'b1;
        idx                       = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one downstream lane among NUM_REQ
// requesters. A grant is held for a whole burst (ended by in_last) and is
// capped at MAX_BURST beats; the data path is a combinational AND-OR mux
// over the registered one-hot grant.
// Ports: clk, rst_n (async active-low), bus (mux_rr_arbiter_if.slave).
// Optional: define ARB_WDOG_EN to release a grant whose owner stalls for
// WDOG_CYCLES consecutive cycles (err pulses once); otherwise err is 0.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = ARB_NUM_REQ,
  parameter int unsigned DATA_WIDTH  = ARB_DATA_WIDTH,
  parameter int unsigned MAX_BURST   = ARB_MAX_BURST,
  parameter int unsigned WDOG_CYCLES = ARB_WDOG_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t           state_q, state_d;
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [SRC_W-1:0]     pick_ptr;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [SRC_W-1:0]     pick_idx;
  logic                 pick_any;

  logic [DATA_WIDTH-1:0] mux_data;
  logic                  valid_g;
  logic                  last_g;
  logic                  cap_hit;
  logic                  beat;
  logic                  end_beat;

  // While granted, the current owner is the rotation base so it ranks last.
  assign pick_ptr = (state_q == ARB_GRANT) ? src_q : ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_pick (
    .req    (bus.in_valid),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // AND-OR output mux; a zero grant (IDLE) forces everything to 0.
  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      mux_data = mux_data | ({DATA_WIDTH{grant_q[i]}} & bus.in_data[i]);
    end
  end

  assign valid_g  = |(grant_q & bus.in_valid);
  assign last_g   = |(grant_q & bus.in_last);
  assign cap_hit  = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign beat     = (state_q == ARB_GRANT) && valid_g && bus.out_ready;
  assign end_beat = beat && (last_g || cap_hit);

  assign bus.out_data  = mux_data;
  assign bus.out_valid = valid_g;
  assign bus.out_last  = valid_g && (last_g || cap_hit);
  assign bus.in_ready  = grant_q & {NUM_REQ{bus.out_ready}};
  assign bus.grant     = grant_q;
  assign bus.out_src   = src_q;

`ifdef ARB_WDOG_EN
  localparam int unsigned STALL_W = $clog2(WDOG_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Next-state: arbitration, burst counting and back-to-back regrant.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    src_d      = src_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
`ifdef ARB_WDOG_EN
    stall_d    = '0;
    err_d      = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_GRANT;
          grant_d    = pick_onehot;
          src_d      = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (end_beat) begin
          ptr_d      = src_q;
          beat_cnt_d = '0;
          if (pick_any) begin
            grant_d = pick_onehot;
            src_d   = pick_idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
`ifdef ARB_WDOG_EN
    // A stalled owner never has a beat, so this cannot collide with end_beat.
    if ((state_q == ARB_GRANT) && !valid_g) begin
      if (stall_q == STALL_W'(WDOG_CYCLES - 1)) begin
        state_d    = ARB_IDLE;
        grant_d    = '0;
        ptr_d      = src_q;
        beat_cnt_d = '0;
        err_d      = 1'b1;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= SRC_W'(NUM_REQ - 1);
      src_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
`ifdef ARB_WDOG_EN
      stall_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      src_q      <= src_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef ARB_WDOG_EN
      stall_q    <= stall_d;
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios plus a random phase,
// all checked against a behavioural round-robin model held in the bench.
module tb_mux_rr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 15;
  localparam int WDOG = 16;

  logic clk;
  logic rst_n;

  mux_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  mux_rr_arbiter #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .MAX_BURST   (MAXB),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: granted requester (-1 = none), rotation pointer, etc.
  int m_g, m_ptr, m_src, m_beats;
  logic m_err;
`ifdef ARB_WDOG_EN
  int m_stall;
`endif

  logic [DW-1:0] dat [NR];

  logic [NR-1:0] obs_grant, obs_ready;
  logic          obs_valid, obs_last;
  logic [DW-1:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int base, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(base + k) % NR]) return (base + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = NR - 1; m_src = 0; m_beats = 0; m_err = 1'b0;
`ifdef ARB_WDOG_EN
    m_stall = 0;
`endif
  endtask

  task automatic model_advance(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic rdy);
    int w;
    m_err = 1'b0;
    if (m_g < 0) begin
      w = pick(m_ptr, v);
      if (w >= 0) begin m_g = w; m_src = w; m_beats = 0; end
`ifdef ARB_WDOG_EN
      m_stall = 0;
`endif
    end else if (v[m_g] && rdy && (l[m_g] || m_beats == MAXB - 1)) begin
      m_ptr = m_g;
      w = pick(m_g, v);
      m_g = w;
      m_beats = 0;
      if (w >= 0) m_src = w;
`ifdef ARB_WDOG_EN
      m_stall = 0;
`endif
    end else begin
      if (v[m_g] && rdy) m_beats++;
`ifdef ARB_WDOG_EN
      if (v[m_g]) m_stall = 0;
      else begin
        m_stall++;
        if (m_stall == WDOG) begin
          m_ptr = m_g; m_g = -1; m_err = 1'b1; m_stall = 0; m_beats = 0;
        end
      end
`endif
    end
  endtask

  // Called at a negedge: drive, check against model, advance model, wait.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic rdy);
    logic [NR-1:0] e_grant, e_ready;
    logic          e_valid, e_last;
    logic [DW-1:0] e_data;
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = rdy;
    for (int i = 0; i < NR; i++) bus.in_data[i] = dat[i];
    #1;
    if (m_g < 0) begin
      e_grant = '0; e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_data = '0;
    end else begin
      e_grant = NR'(1) << m_g;
      e_ready = rdy ? e_grant : '0;
      e_valid = v[m_g];
      e_last  = v[m_g] && (l[m_g] || m_beats == MAXB - 1);
      e_data  = dat[m_g];
    end
    chk("grant",     32'(bus.grant),     32'(e_grant));
    chk("out_src",   32'(bus.out_src),   32'(m_src));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("out_data",  32'(bus.out_data),  32'(e_data));
    chk("out_last",  32'(bus.out_last),  32'(e_last));
    chk("in_ready",  32'(bus.in_ready),  32'(e_ready));
    chk("err",       32'(bus.err),       32'(m_err));
    obs_grant = bus.grant; obs_ready = bus.in_ready; obs_valid = bus.out_valid;
    obs_last  = bus.out_last; obs_data = bus.out_data;
    model_advance(v, l, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = '0; bus.in_last = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin dat[i] = '0; bus.in_data[i] = '0; end
    #1;
    chk("rst_grant", 32'(bus.grant),     32'd0);
    chk("rst_src",   32'(bus.out_src),   32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err",   32'(bus.err),       32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c1, c3;
    int nb;
    int cnt [NR];
    int bsrc [32];
    logic blast [32];
    logic [NR-1:0] l;

    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single requester, 3-beat burst
    step(4'b0100, 4'b0000, 1'b1);
    chk("t1_grant", 32'(bus.grant),   32'h4);
    chk("t1_src",   32'(bus.out_src), 32'd2);
    dat[2] = 8'hA1; step(4'b0100, 4'b0000, 1'b1);
    chk("t1_beatA", 32'(obs_data), 32'hA1);
    dat[2] = 8'hB2; step(4'b0100, 4'b0000, 1'b1);
    dat[2] = 8'hC3; step(4'b0100, 4'b0100, 1'b1);
    chk("t1_beatC",   32'(obs_data), 32'hC3);
    chk("t1_lastC",   32'(obs_last), 32'd1);

    // all valid, 2-beat bursts: strict rotation without bubbles
    do_reset();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int k = 0; k <= 16; k++) begin
      for (int i = 0; i < NR; i++) l[i] = (cnt[i] == 1);
      step(4'b1111, l, 1'b1);
      if (k > 0) begin
        chk("t2_order", 32'(obs_grant), 32'(1 << (((k - 1) / 2) % NR)));
        chk("t2_nobubble", 32'(obs_valid), 32'd1);
      end
      for (int i = 0; i < NR; i++) if (obs_ready[i]) cnt[i] = (cnt[i] + 1) % 2;
    end

    // 20-beat burst against the 15-beat cap
    do_reset();
    c1 = 0; c3 = 0; nb = 0;
    for (int k = 0; k < 24; k++) begin
      l = {c3 == 1, 1'b0, c1 == 19, 1'b0};
      dat[1] = 8'(c1); dat[3] = 8'(8'h80 + c3);
      step(4'b1010, l, 1'b1);
      if (obs_ready[1] && nb < 32) begin bsrc[nb] = 1; blast[nb] = obs_last; nb++; c1++; end
      else if (obs_ready[3] && nb < 32) begin bsrc[nb] = 3; blast[nb] = obs_last; nb++; c3 = (c3 + 1) % 2; end
    end
    chk("t3_nbeats",  32'(nb),        32'd23);
    chk("t3_b13last", 32'(blast[13]), 32'd0);
    chk("t3_b14src",  32'(bsrc[14]),  32'd1);
    chk("t3_b14last", 32'(blast[14]), 32'd1);
    chk("t3_b15src",  32'(bsrc[15]),  32'd3);
    chk("t3_b17src",  32'(bsrc[17]),  32'd1);
    chk("t3_b21src",  32'(bsrc[21]),  32'd1);
    chk("t3_b21last", 32'(blast[21]), 32'd1);
    chk("t3_b22src",  32'(bsrc[22]),  32'd3);

    // downstream backpressure mid-burst
    do_reset();
    step(4'b0001, 4'b0000, 1'b1);
    dat[0] = 8'h11; step(4'b0001, 4'b0000, 1'b1);
    dat[0] = 8'h22;
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 4'b0000, 1'b0);
      chk("t4_data",  32'(obs_data),  32'h22);
      chk("t4_grant", 32'(obs_grant), 32'h1);
      chk("t4_ready", 32'(obs_ready), 32'h0);
    end
    step(4'b0001, 4'b0000, 1'b1);
    dat[0] = 8'h33; step(4'b0001, 4'b0000, 1'b1);
    chk("t4_nolast3", 32'(obs_last), 32'd0);
    dat[0] = 8'h44; step(4'b0001, 4'b0001, 1'b1);
    chk("t4_last4", 32'(obs_last), 32'd1);

    // asynchronous reset during beat 2 of 4
    do_reset();
    step(4'b0010, 4'b0000, 1'b1);
    dat[1] = 8'hB1; step(4'b0010, 4'b0000, 1'b1);
    dat[1] = 8'hB2;
    bus.in_valid = 4'b0010; bus.in_last = '0; bus.out_ready = 1'b1; bus.in_data[1] = dat[1];
    #1;
    chk("t5_beat2", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_grant", 32'(bus.grant),     32'd0);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_ready", 32'(bus.in_ready),  32'd0);
    chk("t5_last",  32'(bus.out_last),  32'd0);
    chk("t5_data",  32'(bus.out_data),  32'd0);
    chk("t5_src",   32'(bus.out_src),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1100, 4'b0000, 1'b1);
    chk("t5_regrant", 32'(bus.grant), 32'h4);

    // owner stalls after one beat while requester 2 waits
    do_reset();
    step(4'b0101, 4'b0000, 1'b1);
    step(4'b0101, 4'b0000, 1'b1);
    for (int k = 0; k < 20; k++) begin
`ifdef ARB_WDOG_EN
      if (k <= 15) chk("t6_hold", 32'(bus.grant), 32'h1);
      if (k == 16) begin
        chk("t6_release", 32'(bus.grant), 32'h0);
        chk("t6_err",     32'(bus.err),   32'd1);
      end
      if (k == 17) begin
        chk("t6_next",   32'(bus.grant), 32'h4);
        chk("t6_errlow", 32'(bus.err),   32'd0);
      end
`else
      chk("t6_hold",  32'(bus.grant), 32'h1);
      chk("t6_noerr", 32'(bus.err),   32'd0);
`endif
      step(4'b0100, 4'b0000, 1'b1);
    end

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NR; i++) dat[i] = 8'($urandom);
      step(NR'($urandom | $urandom), NR'($urandom & $urandom & $urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
